// File: rtl/i2c_cfg_sequencer.sv
// Configuration sequencer: walks a writable table of I2C write commands and
// hands them one at a time to the I2C master over its start/ready handshake.
module i2c_cfg_sequencer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_waddr,
    input  logic [22:0]   tbl_wdata,
    input  logic          go,
    input  logic [AW:0]   count,
    input  logic          abort,
    output logic          m_start,
    output logic [6:0]    m_addr,
    output logic [7:0]    m_sub,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] cur_idx
);

    localparam int unsigned TMR_W = 10;
    localparam int unsigned ENT_W = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               ld_ph_q, ld_ph_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               tmr_en;
    logic               m_start_q, m_start_d;
    logic [6:0]         m_addr_q, m_addr_d;
    logic [7:0]         m_sub_q, m_sub_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               tmr_hit, gap_hit, last_ent;

    logic [ENT_W-1:0]   tbl [DEPTH];
    logic [ENT_W-1:0]   rd_q;

    // Command table: writes locked out while a sequence runs; registered read
    always_ff @(posedge clk) begin
        if (tbl_we && !busy_q) begin
            tbl[tbl_waddr] <= tbl_wdata;
        end
        rd_q <= tbl[idx_q];
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ld_ph_q   <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_sub_q   <= '0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_ph_q   <= ld_ph_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            m_start_q <= m_start_d;
            m_addr_q  <= m_addr_d;
            m_sub_q   <= m_sub_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state and next-output logic; abort overrides everything else
    always_comb begin
        state_d   = state_q;
        ld_ph_d   = ld_ph_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        m_start_d = m_start_q;
        m_addr_d  = m_addr_q;
        m_sub_d   = m_sub_q;
        m_data_d  = m_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        tmr_en    = 1'b0;
        tmr_hit   = (tmr_q == TMR_W'(TIMEOUT));
        gap_hit   = (tmr_q == TMR_W'(GAP_CYCLES - 1));
        last_ent  = ({1'b0, idx_q} == (cnt_q - (AW+1)'(1)));

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
                        error_d = 1'b0;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        ld_ph_d = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (!ld_ph_q) begin
                    ld_ph_d = 1'b1;
                end else begin
                    m_addr_d = rd_q[22:16];
                    m_sub_d  = rd_q[15:8];
                    m_data_d = rd_q[7:0];
                    tmr_en   = 1'b1;
                    if (m_ready) begin
                        m_start_d = 1'b1;
                        state_d   = S_ISSUE;
                    end else if (tmr_hit) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ISSUE: begin
                tmr_en = 1'b1;
                if (!m_ready) begin
                    m_start_d = 1'b0;
                    state_d   = S_WAIT_DONE;
                end else if (tmr_hit) begin
                    m_start_d = 1'b0;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                tmr_en = 1'b1;
                if (m_ready) begin
                    if (last_ent) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_GAP;
                    end
                end else if (tmr_hit) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                tmr_en = 1'b1;
                if (gap_hit) begin
                    ld_ph_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            idx_d     = idx_q;
            m_start_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            error_d   = error_q;
        end

        // One shared timer: restarts on every state change
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tmr_en) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = tmr_q;
        end
    end

    assign m_start = m_start_q;
    assign m_addr  = m_addr_q;
    assign m_sub   = m_sub_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign cur_idx = idx_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for the configuration sequencer with a behavioural master.
module tb_i2c_cfg_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TMO   = 1023;

    localparam int K_TXN  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int         kind;
        logic [6:0] a;
        logic [7:0] s;
        logic [7:0] d;
        int         idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_waddr = '0;
    logic [22:0]   tbl_wdata = '0;
    logic          go = 1'b0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic          m_start;
    logic [6:0]    m_addr;
    logic [7:0]    m_sub;
    logic [7:0]    m_data;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] cur_idx;

    exp_t          expq[$];
    exp_t          mon_e;
    logic [22:0]   ref_tbl [DEPTH];
    int            vectors = 0;
    int            miscompares = 0;
    int            done_seen = 0;
    int            mode = 0;
    int            lat_lo = 1;
    int            lat_hi = 40;
    logic          prev_start = 1'b0;
    logic          prev_err = 1'b0;
    int            rdy_hi = 0;
    bit            in_run = 1'b0;

    i2c_cfg_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata), .go(go), .count(count), .abort(abort),
        .m_start(m_start), .m_addr(m_addr), .m_sub(m_sub), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .done(done), .error(error),
        .cur_idx(cur_idx)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.kind = K_TXN;
            e.a    = ref_tbl[i][22:16];
            e.s    = ref_tbl[i][15:8];
            e.d    = ref_tbl[i][7:0];
            e.idx  = i;
            expq.push_back(e);
        end
        e = '{kind: K_DONE, a: '0, s: '0, d: '0, idx: 0};
        expq.push_back(e);
    endtask

    task automatic write_tbl(input int i, input logic [22:0] v, input bit honoured);
        @(posedge clk);
        #1;
        tbl_we    = 1'b1;
        tbl_waddr = AW'(i);
        tbl_wdata = v;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        if (honoured) ref_tbl[i] = v;
    endtask

    task automatic go_run(input int n);
        @(posedge clk);
        #1;
        go    = 1'b1;
        count = (AW+1)'(n);
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_budget"}, 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    // Behavioural master: drops ready two clocks after a start, raises it later
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (reset && m_start && m_ready && mode == 0) begin
                lat = $urandom_range(lat_hi, lat_lo);
                repeat (2) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (lat) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues, finishes or errors
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_start = 1'b0;
                prev_err   = 1'b0;
                in_run     = 1'b0;
                rdy_hi     = 0;
            end else begin
                if (m_start && !prev_start) begin
                    if (expq.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        mon_e = expq.pop_front();
                        check("start_kind", K_TXN, mon_e.kind);
                        check("m_addr", 32'(m_addr), 32'(mon_e.a));
                        check("m_sub", 32'(m_sub), 32'(mon_e.s));
                        check("m_data", 32'(m_data), 32'(mon_e.d));
                        check("start_cur_idx", 32'(cur_idx), mon_e.idx);
                        check("start_busy", 32'(busy), 1);
                    end
                    if (in_run) check("gap_idle_clocks", 32'(rdy_hi >= GAP + 2), 1);
                    in_run = 1'b1;
                end
                if (done) begin
                    done_seen++;
                    if (expq.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        mon_e = expq.pop_front();
                        check("done_kind", K_DONE, mon_e.kind);
                        check("done_busy", 32'(busy), 0);
                    end
                end
                if (error && !prev_err) begin
                    if (expq.size() == 0) begin
                        check("unexpected_error", 1, 0);
                    end else begin
                        mon_e = expq.pop_front();
                        check("error_kind", K_ERR, mon_e.kind);
                        check("error_m_start", 32'(m_start), 0);
                        check("error_busy", 32'(busy), 0);
                    end
                end
                if (!m_ready) rdy_hi = 0;
                else if (!m_start) rdy_hi++;
                if (!busy) in_run = 1'b0;
                prev_start = m_start;
                prev_err   = error;
            end
        end
    end

    initial begin
        int   d0;
        int   n;
        exp_t e;

        #12;
        check("reset_m_start", 32'(m_start), 0);
        check("reset_m_fields", 32'({m_addr, m_sub, m_data}), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_cur_idx", 32'(cur_idx), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_tbl(i, 23'($urandom), 1'b1);

        // Directed three-entry sequence, master latency fixed at 40
        write_tbl(0, {7'h55, 8'hAA, 8'hAA}, 1'b1);
        write_tbl(1, {7'h68, 8'h20, 8'h0F}, 1'b1);
        write_tbl(2, {7'h68, 8'h23, 8'h30}, 1'b1);
        lat_lo = 40;
        lat_hi = 40;
        push_run(3);
        d0 = done_seen;
        go_run(3);
        @(negedge clk);
        check("dir_busy_high", 32'(busy), 1);
        wait_idle("dir", 3000);
        check("dir_done_count", done_seen - d0, 1);
        check("dir_error", 32'(error), 0);
        check("dir_cur_idx", 32'(cur_idx), 2);
        check("dir_queue_empty", expq.size(), 0);

        // count = 0: done next cycle, nothing issued
        push_run(0);
        go_run(0);
        @(negedge clk);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        check("zero_queue_empty", expq.size(), 0);

        // Randomised runs over random table contents
        lat_lo = 1;
        lat_hi = 12;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) write_tbl(i, 23'($urandom), 1'b1);
            n = (r == 0) ? DEPTH : $urandom_range(DEPTH, 1);
            push_run(n);
            d0 = done_seen;
            go_run(n);
            wait_idle("rand", 4000);
            check("rand_done_count", done_seen - d0, 1);
            check("rand_cur_idx", 32'(cur_idx), n - 1);
            check("rand_queue_empty", expq.size(), 0);
        end

        // Master never accepts: timeout
        mode = 1;
        push_run(1);
        void'(expq.pop_back());
        e = '{kind: K_ERR, a: '0, s: '0, d: '0, idx: 0};
        expq.push_back(e);
        d0 = done_seen;
        go_run(1);
        n = 0;
        while (!error && n < 1300) begin
            @(negedge clk);
            n++;
        end
        check("tmo_error", 32'(error), 1);
        check("tmo_latency_in_range", 32'(n >= TMO && n <= TMO + 16), 1);
        check("tmo_m_start", 32'(m_start), 0);
        check("tmo_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("tmo_no_done", done_seen - d0, 0);
        check("tmo_queue_empty", expq.size(), 0);
        mode = 0;
        push_run(1);
        go_run(1);
        @(negedge clk);
        check("tmo_error_cleared", 32'(error), 0);
        wait_idle("tmo_rerun", 500);
        check("tmo_rerun_queue_empty", expq.size(), 0);

        // Abort during the wait for entry 1 to complete
        lat_lo = 40;
        lat_hi = 40;
        for (int i = 0; i < 2; i++) begin
            e.kind = K_TXN;
            e.a    = ref_tbl[i][22:16];
            e.s    = ref_tbl[i][15:8];
            e.d    = ref_tbl[i][7:0];
            e.idx  = i;
            expq.push_back(e);
        end
        d0 = done_seen;
        go_run(3);
        n = 0;
        while (!(cur_idx == AW'(1) && !m_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_entry1", 32'(cur_idx == AW'(1) && !m_ready), 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_cur_idx", 32'(cur_idx), 1);
        check("abort_m_start", 32'(m_start), 0);
        n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_queue_empty", expq.size(), 0);
        check("abort_error_kept", 32'(error), 0);

        // Table write while busy must be ignored
        lat_lo = 3;
        lat_hi = 8;
        push_run(2);
        go_run(2);
        write_tbl(0, 23'h7FFFFF, 1'b0);
        wait_idle("we_busy", 1000);
        push_run(1);
        go_run(1);
        wait_idle("we_rerun", 500);
        check("we_queue_empty", expq.size(), 0);

        // Reset while m_start is asserted
        mode = 1;
        push_run(1);
        go_run(1);
        n = 0;
        while (!m_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_saw_start", 32'(m_start), 1);
        #2 reset = 1'b0;
        #1;
        check("rst_m_start", 32'(m_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        expq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mode  = 0;
        push_run(1);
        d0 = done_seen;
        go_run(1);
        wait_idle("rst_rerun", 500);
        check("rst_rerun_done", done_seen - d0, 1);
        check("rst_rerun_queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
